wb_ctrl: RTL and testbench
==========================

# wb_ctrl

Write-back stage and pipeline control unit: the consumer of the MEM/WB pipeline register. It commits register writes to the GPR file and executes control-register writes and ERET. It accepts exceptions and external interrupts at the commit point and drives the global stall, flush and new-PC signals for the IF/ID/EX/MEM stages. It holds the architectural control registers: STATUS, INT_MASK, EXP_CAUSE, EPC and EXP_VECTOR.

## Interface
- Parameters: none. Widths are fixed: 32-bit data/address, 5-bit register address, 8 IRQ lines.
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high
- mem_pc  in  32  PC of the instruction in WB
- mem_en  in  1  WB slot holds a valid instruction
- mem_br_flag  in  1  instruction is in a branch delay slot
- mem_ctrl_op  in  2  00 NOP, 01 WRCR, 10 ERET, 11 treated as NOP
- mem_dst_addr  in  5  GPR destination, or control-register address for WRCR
- mem_gpr_we_  in  1  GPR write enable, active-low
- mem_exp_code  in  3  0 none, 1 EXT_INT, 2 UNDEF, 3 OVERFLOW, 4 MISS_ALIGN, 5 TRAP, 6 PRV_VIO
- mem_out  in  32  result / write data
- irq  in  8  asynchronous external interrupt requests, active-high level
- if_busy, mem_busy  in  1 each  memory port wait requests
- creg_rd_addr  in  5  control-register read address (from EX)
- creg_rd_data  out  32  control-register read data (combinational)
- gpr_we_, gpr_wr_addr, gpr_wr_data  out  1/5/32  GPR write port
- if_stall, id_stall, ex_stall, mem_stall  out  1 each
- if_flush, id_flush, ex_flush, mem_flush  out  1 each
- new_pc  out  32  redirect target, valid while flush is asserted

## Operation
- Control registers, by address:
  - 0 STATUS {30'b0, PIE, IE}
  - 1 INT_MASK[7:0]; 1 = masked
  - 2 EXP_CAUSE {28'b0, br_flag, code[2:0]}
  - 3 EPC
  - 4 EXP_VECTOR
  - Other addresses read 0; writes to them are ignored.
- Reset values: STATUS 0, INT_MASK 8'hFF, EXP_CAUSE 0, EPC 0, EXP_VECTOR 0, IRQ synchroniser 0.
- IRQ path: 2-flop synchroniser, giving irq_s. int_pend = IE & |(irq_s & ~INT_MASK).
- stall_all = if_busy | mem_busy. All four stall outputs equal stall_all.
- Event decode applies only when mem_en=1 and stall_all=0; otherwise nothing commits and all flushes are 0. Priority:
  1. mem_exp_code != 0 → exception, cause = mem_exp_code.
  2. Else int_pend → interrupt, cause = 1 (EXT_INT). The WB instruction is not committed.
  3. Else ERET.
  4. Else WRCR, or a normal GPR write.
- Exception or interrupt:
  - All four flushes = 1; new_pc = EXP_VECTOR.
  - At the edge: EPC ← mem_br_flag ? mem_pc−4 : mem_pc; EXP_CAUSE ← {mem_br_flag, cause}; PIE ← IE; IE ← 0.
- ERET:
  - All flushes = 1; new_pc = EPC.
  - At the edge: IE ← PIE.
- WRCR: at the edge, creg[mem_dst_addr] ← mem_out, truncated to the register width. No flush.
- GPR write:
  - gpr_we_ = 0 only when mem_en=1, stall_all=0, no exception or interrupt is taken, and mem_gpr_we_=0. Otherwise gpr_we_ = 1.
  - gpr_wr_addr = mem_dst_addr; gpr_wr_data = mem_out.
- When no flush is asserted, new_pc = 0.

## Timing
- Decode is combinational. An event visible in cycle N drives flush and new_pc during cycle N. Register updates occur on the edge ending cycle N. The GPR write completes on that same edge.
- creg_rd_data returns the pre-edge value. A WRCR in WB is not forwarded to a same-cycle read.
- IRQ latency: 2 cycles through the synchroniser, then taken on the next cycle in which WB holds a valid, non-excepting instruction and stall_all=0.
- Stall held across many cycles: state is frozen, and the pending event is taken on the first unstalled cycle.
- Reset mid-operation: all registers return to their reset values immediately. Outputs follow the reset-valued MEM/WB inputs (gpr_we_=1, flushes 0).
- An exception on an ERET or WRCR instruction takes precedence; the ERET or WRCR is not executed.

## Test plan
- Normal write: mem_en=1, gpr_we_=0, dst=5, out=32'h1234, no busy → gpr_we_=0 with addr 5 and data 32'h1234 in the same cycle; no flush.
- Misalign exception: exp_code=4, pc=32'h100, br_flag=1, EXP_VECTOR=32'h40 → all flushes=1, new_pc=32'h40. Next cycle: EPC=32'hFC, EXP_CAUSE=32'hC, IE=0, PIE=old IE.
- Interrupt: write STATUS=1 and INT_MASK=8'hFE, pulse irq[0]; valid instruction at 32'h200 → taken 2 cycles after irq rises, EPC=32'h200, cause=1, gpr_we_=1 in that cycle.
- ERET: EPC=32'h300, PIE=1 → new_pc=32'h300, flushes=1, IE=1 after the edge.
- Stall: mem_busy=1 for 3 cycles with exp_code=5 pending → no flush and no register change for 3 cycles; the exception is taken on the 4th cycle.
- Reset mid-exception: assert reset in the cycle the flush is asserted → STATUS=0, INT_MASK=8'hFF, EPC=0 immediately.

Source files
------------

// File: rtl/wb_ctrl.sv
// Write-back stage and pipeline control: commits GPR writes, owns the control
// registers, takes exceptions/interrupts at commit and drives stall/flush/new_pc.
module wb_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_pc,
    input  logic        mem_en,
    input  logic        mem_br_flag,
    input  logic [1:0]  mem_ctrl_op,
    input  logic [4:0]  mem_dst_addr,
    input  logic        mem_gpr_we_,
    input  logic [2:0]  mem_exp_code,
    input  logic [31:0] mem_out,
    input  logic [7:0]  irq,
    input  logic        if_busy,
    input  logic        mem_busy,
    input  logic [4:0]  creg_rd_addr,
    output logic [31:0] creg_rd_data,
    output logic        gpr_we_,
    output logic [4:0]  gpr_wr_addr,
    output logic [31:0] gpr_wr_data,
    output logic        if_stall,
    output logic        id_stall,
    output logic        ex_stall,
    output logic        mem_stall,
    output logic        if_flush,
    output logic        id_flush,
    output logic        ex_flush,
    output logic        mem_flush,
    output logic [31:0] new_pc
);

    typedef enum logic [1:0] {
        CTRL_NOP  = 2'b00,
        CTRL_WRCR = 2'b01,
        CTRL_ERET = 2'b10,
        CTRL_RSVD = 2'b11
    } ctrl_op_e;

    localparam logic [4:0] CR_STATUS     = 5'd0;
    localparam logic [4:0] CR_INT_MASK   = 5'd1;
    localparam logic [4:0] CR_EXP_CAUSE  = 5'd2;
    localparam logic [4:0] CR_EPC        = 5'd3;
    localparam logic [4:0] CR_EXP_VECTOR = 5'd4;

    localparam logic [2:0] EXP_EXT_INT = 3'd1;

    // status bit 1 is PIE, bit 0 is IE
    logic [1:0]  status_q, status_d;
    logic [7:0]  int_mask_q, int_mask_d;
    logic [3:0]  exp_cause_q, exp_cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] exp_vector_q, exp_vector_d;
    logic [7:0]  irq_meta_q, irq_meta_d;
    logic [7:0]  irq_sync_q, irq_sync_d;

    logic       stall_all;
    logic       commit_slot;
    logic       int_pend;
    logic       take_exp;
    logic       take_int;
    logic       take_trap;
    logic       take_eret;
    logic       take_wrcr;
    logic       flush_all;
    logic [2:0] trap_cause;
    ctrl_op_e   ctrl_op;

    always_comb begin
        ctrl_op     = ctrl_op_e'(mem_ctrl_op);
        stall_all   = if_busy | mem_busy;
        commit_slot = mem_en & ~stall_all;
        int_pend    = status_q[0] & (|(irq_sync_q & ~int_mask_q));
        take_exp    = commit_slot & (mem_exp_code != 3'd0);
        take_int    = commit_slot & (mem_exp_code == 3'd0) & int_pend;
        take_trap   = take_exp | take_int;
        take_eret   = commit_slot & ~take_trap & (ctrl_op == CTRL_ERET);
        take_wrcr   = commit_slot & ~take_trap & (ctrl_op == CTRL_WRCR);
        flush_all   = take_trap | take_eret;
        trap_cause  = take_exp ? mem_exp_code : EXP_EXT_INT;
    end

    always_comb begin
        if_stall    = stall_all;
        id_stall    = stall_all;
        ex_stall    = stall_all;
        mem_stall   = stall_all;
        if_flush    = flush_all;
        id_flush    = flush_all;
        ex_flush    = flush_all;
        mem_flush   = flush_all;
        new_pc      = 32'd0;
        if (take_trap) begin
            new_pc = exp_vector_q;
        end else if (take_eret) begin
            new_pc = epc_q;
        end
        gpr_we_     = ~(commit_slot & ~take_trap & ~mem_gpr_we_);
        gpr_wr_addr = mem_dst_addr;
        gpr_wr_data = mem_out;
    end

    // Reads see the pre-edge value; a WRCR in WB is deliberately not forwarded.
    always_comb begin
        creg_rd_data = 32'd0;
        case (creg_rd_addr)
            CR_STATUS:     creg_rd_data = {30'd0, status_q};
            CR_INT_MASK:   creg_rd_data = {24'd0, int_mask_q};
            CR_EXP_CAUSE:  creg_rd_data = {28'd0, exp_cause_q};
            CR_EPC:        creg_rd_data = epc_q;
            CR_EXP_VECTOR: creg_rd_data = exp_vector_q;
            default:       creg_rd_data = 32'd0;
        endcase
    end

    always_comb begin
        status_d     = status_q;
        int_mask_d   = int_mask_q;
        exp_cause_d  = exp_cause_q;
        epc_d        = epc_q;
        exp_vector_d = exp_vector_q;
        irq_meta_d   = irq;
        irq_sync_d   = irq_meta_q;
        if (take_trap) begin
            // In a delay slot, resume at the branch so it is re-executed.
            epc_d       = mem_br_flag ? (mem_pc - 32'd4) : mem_pc;
            exp_cause_d = {mem_br_flag, trap_cause};
            status_d    = {status_q[0], 1'b0};
        end else if (take_eret) begin
            status_d    = {status_q[1], status_q[1]};
        end else if (take_wrcr) begin
            case (mem_dst_addr)
                CR_STATUS:     status_d     = mem_out[1:0];
                CR_INT_MASK:   int_mask_d   = mem_out[7:0];
                CR_EXP_CAUSE:  exp_cause_d  = mem_out[3:0];
                CR_EPC:        epc_d        = mem_out;
                CR_EXP_VECTOR: exp_vector_d = mem_out;
                default:       ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            status_q     <= 2'd0;
            int_mask_q   <= 8'hFF;
            exp_cause_q  <= 4'd0;
            epc_q        <= 32'd0;
            exp_vector_q <= 32'd0;
            irq_meta_q   <= 8'd0;
            irq_sync_q   <= 8'd0;
        end else begin
            status_q     <= status_d;
            int_mask_q   <= int_mask_d;
            exp_cause_q  <= exp_cause_d;
            epc_q        <= epc_d;
            exp_vector_q <= exp_vector_d;
            irq_meta_q   <= irq_meta_d;
            irq_sync_q   <= irq_sync_d;
        end
    end

endmodule

// File: tb/tb_wb_ctrl.sv
// Self-checking bench for wb_ctrl: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_wb_ctrl;

    logic        clk;
    logic        reset;
    logic [31:0] mem_pc;
    logic        mem_en;
    logic        mem_br_flag;
    logic [1:0]  mem_ctrl_op;
    logic [4:0]  mem_dst_addr;
    logic        mem_gpr_we_;
    logic [2:0]  mem_exp_code;
    logic [31:0] mem_out;
    logic [7:0]  irq;
    logic        if_busy;
    logic        mem_busy;
    logic [4:0]  creg_rd_addr;
    logic [31:0] creg_rd_data;
    logic        gpr_we_;
    logic [4:0]  gpr_wr_addr;
    logic [31:0] gpr_wr_data;
    logic        if_stall, id_stall, ex_stall, mem_stall;
    logic        if_flush, id_flush, ex_flush, mem_flush;
    logic [31:0] new_pc;

    int checks = 0;
    int errors = 0;

    wb_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .mem_pc       (mem_pc),
        .mem_en       (mem_en),
        .mem_br_flag  (mem_br_flag),
        .mem_ctrl_op  (mem_ctrl_op),
        .mem_dst_addr (mem_dst_addr),
        .mem_gpr_we_  (mem_gpr_we_),
        .mem_exp_code (mem_exp_code),
        .mem_out      (mem_out),
        .irq          (irq),
        .if_busy      (if_busy),
        .mem_busy     (mem_busy),
        .creg_rd_addr (creg_rd_addr),
        .creg_rd_data (creg_rd_data),
        .gpr_we_      (gpr_we_),
        .gpr_wr_addr  (gpr_wr_addr),
        .gpr_wr_data  (gpr_wr_data),
        .if_stall     (if_stall),
        .id_stall     (id_stall),
        .ex_stall     (ex_stall),
        .mem_stall    (mem_stall),
        .if_flush     (if_flush),
        .id_flush     (id_flush),
        .ex_flush     (ex_flush),
        .mem_flush    (mem_flush),
        .new_pc       (new_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: control registers as a plain array, IRQ as a 2-cycle delay line.
    typedef enum {EV_NONE, EV_EXC, EV_INT, EV_ERET, EV_WRCR} event_e;
    logic [31:0] m_creg [5];
    logic [31:0] m_width_mask [5];
    logic [7:0]  m_irq_d1, m_irq_s;
    event_e      m_event;
    logic [2:0]  m_cause;
    logic        m_stall, m_flush, m_gpr_we_n;
    logic [31:0] m_new_pc;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_creg[0] = 32'd0;
        m_creg[1] = 32'h0000_00FF;
        m_creg[2] = 32'd0;
        m_creg[3] = 32'd0;
        m_creg[4] = 32'd0;
        m_irq_d1  = 8'd0;
        m_irq_s   = 8'd0;
    endtask

    task automatic predict();
        logic trap;
        m_stall = if_busy | mem_busy;
        m_event = EV_NONE;
        m_cause = 3'd0;
        if (mem_en && !m_stall) begin
            if (mem_exp_code != 3'd0) begin
                m_event = EV_EXC;
                m_cause = mem_exp_code;
            end else if (m_creg[0][0] && ((m_irq_s & ~m_creg[1][7:0]) != 8'd0)) begin
                m_event = EV_INT;
                m_cause = 3'd1;
            end else if (mem_ctrl_op == 2'd2) begin
                m_event = EV_ERET;
            end else if (mem_ctrl_op == 2'd1) begin
                m_event = EV_WRCR;
            end
        end
        trap       = (m_event == EV_EXC) || (m_event == EV_INT);
        m_flush    = trap || (m_event == EV_ERET);
        m_new_pc   = trap ? m_creg[4] : ((m_event == EV_ERET) ? m_creg[3] : 32'd0);
        m_gpr_we_n = !(mem_en && !m_stall && !trap && !mem_gpr_we_);
    endtask

    task automatic commitModel();
        logic ie, pie;
        ie  = m_creg[0][0];
        pie = m_creg[0][1];
        case (m_event)
            EV_EXC, EV_INT: begin
                m_creg[3] = mem_br_flag ? mem_pc - 32'd4 : mem_pc;
                m_creg[2] = {28'd0, mem_br_flag, m_cause};
                m_creg[0] = {30'd0, ie, 1'b0};
            end
            EV_ERET: m_creg[0] = {30'd0, pie, pie};
            EV_WRCR: if (mem_dst_addr < 5'd5) m_creg[mem_dst_addr] = mem_out & m_width_mask[mem_dst_addr];
            default: ;
        endcase
        m_irq_s  = m_irq_d1;
        m_irq_d1 = irq;
    endtask

    // Single per-cycle comparison of every DUT output against the model.
    task automatic compareAll();
        logic [31:0] exp_rd;
        predict();
        exp_rd = (creg_rd_addr < 5'd5) ? m_creg[creg_rd_addr] : 32'd0;
        checkOutput("if_stall",  32'(if_stall),  32'(m_stall));
        checkOutput("id_stall",  32'(id_stall),  32'(m_stall));
        checkOutput("ex_stall",  32'(ex_stall),  32'(m_stall));
        checkOutput("mem_stall", 32'(mem_stall), 32'(m_stall));
        checkOutput("if_flush",  32'(if_flush),  32'(m_flush));
        checkOutput("id_flush",  32'(id_flush),  32'(m_flush));
        checkOutput("ex_flush",  32'(ex_flush),  32'(m_flush));
        checkOutput("mem_flush", 32'(mem_flush), 32'(m_flush));
        checkOutput("new_pc",    new_pc,          m_new_pc);
        checkOutput("gpr_we_",   32'(gpr_we_),   32'(m_gpr_we_n));
        checkOutput("gpr_wr_addr", 32'(gpr_wr_addr), 32'(mem_dst_addr));
        checkOutput("gpr_wr_data", gpr_wr_data,   mem_out);
        checkOutput("creg_rd_data", creg_rd_data, exp_rd);
    endtask

    task automatic applyStimulus(input logic en, input logic [31:0] pc, input logic br,
                                 input logic [1:0] op, input logic [4:0] dst, input logic we_n,
                                 input logic [2:0] code, input logic [31:0] data,
                                 input logic ibusy, input logic mbusy, input logic [7:0] irqv);
        mem_en       = en;
        mem_pc       = pc;
        mem_br_flag  = br;
        mem_ctrl_op  = op;
        mem_dst_addr = dst;
        mem_gpr_we_  = we_n;
        mem_exp_code = code;
        mem_out      = data;
        if_busy      = ibusy;
        mem_busy     = mbusy;
        irq          = irqv;
        creg_rd_addr = 5'd0;
    endtask

    task automatic applyIdle();
        applyStimulus(1'b0, 32'd0, 1'b0, 2'd0, 5'd0, 1'b1, 3'd0, 32'd0, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic wrcr(input logic [4:0] addr, input logic [31:0] data);
        applyStimulus(1'b1, 32'h10, 1'b0, 2'd1, addr, 1'b1, 3'd0, data, 1'b0, 1'b0, 8'd0);
        evalCycle();
        endCycle();
    endtask

    task automatic evalCycle();
        @(negedge clk);
        compareAll();
    endtask

    task automatic endCycle();
        @(posedge clk);
        commitModel();
        #1;
    endtask

    task automatic readCreg(input string name, input logic [4:0] addr, input logic [31:0] expected);
        creg_rd_addr = addr;
        #1;
        checkOutput(name, creg_rd_data, expected);
    endtask

    initial begin
        m_width_mask[0] = 32'h0000_0003;
        m_width_mask[1] = 32'h0000_00FF;
        m_width_mask[2] = 32'h0000_000F;
        m_width_mask[3] = 32'hFFFF_FFFF;
        m_width_mask[4] = 32'hFFFF_FFFF;
        modelReset();
        applyIdle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        readCreg("reset_status", 5'd0, 32'd0);
        readCreg("reset_int_mask", 5'd1, 32'h0000_00FF);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Normal GPR write
        applyStimulus(1'b1, 32'h0, 1'b0, 2'd0, 5'd5, 1'b0, 3'd0, 32'h1234, 1'b0, 1'b0, 8'd0);
        evalCycle();
        checkOutput("wr_we_", 32'(gpr_we_), 32'd0);
        checkOutput("wr_addr", 32'(gpr_wr_addr), 32'd5);
        checkOutput("wr_data", gpr_wr_data, 32'h1234);
        checkOutput("wr_noflush", 32'(if_flush), 32'd0);
        endCycle();

        // Misaligned access in a delay slot
        wrcr(5'd4, 32'h40);
        wrcr(5'd0, 32'h1);
        applyStimulus(1'b1, 32'h100, 1'b1, 2'd0, 5'd2, 1'b0, 3'd4, 32'h0, 1'b0, 1'b0, 8'd0);
        evalCycle();
        checkOutput("mis_flush", {28'd0, if_flush, id_flush, ex_flush, mem_flush}, 32'hF);
        checkOutput("mis_new_pc", new_pc, 32'h40);
        checkOutput("mis_we_", 32'(gpr_we_), 32'd1);
        endCycle();
        applyIdle();
        evalCycle();
        readCreg("mis_epc", 5'd3, 32'hFC);
        readCreg("mis_cause", 5'd2, 32'hC);
        readCreg("mis_status", 5'd0, 32'h2);
        endCycle();

        // External interrupt on irq[0]
        wrcr(5'd0, 32'h1);
        wrcr(5'd1, 32'hFE);
        applyStimulus(1'b0, 32'h0, 1'b0, 2'd0, 5'd0, 1'b1, 3'd0, 32'h0, 1'b0, 1'b0, 8'h01);
        evalCycle();
        endCycle();
        applyStimulus(1'b1, 32'h1FC, 1'b0, 2'd0, 5'd6, 1'b1, 3'd0, 32'h0, 1'b0, 1'b0, 8'h00);
        evalCycle();
        checkOutput("int_not_yet", 32'(if_flush), 32'd0);
        endCycle();
        applyStimulus(1'b1, 32'h200, 1'b0, 2'd0, 5'd7, 1'b0, 3'd0, 32'hAA, 1'b0, 1'b0, 8'h00);
        evalCycle();
        checkOutput("int_flush", 32'(if_flush), 32'd1);
        checkOutput("int_new_pc", new_pc, 32'h40);
        checkOutput("int_we_", 32'(gpr_we_), 32'd1);
        endCycle();
        applyIdle();
        evalCycle();
        readCreg("int_epc", 5'd3, 32'h200);
        readCreg("int_cause", 5'd2, 32'h1);
        endCycle();

        // ERET back to 0x300 with PIE set
        wrcr(5'd3, 32'h300);
        wrcr(5'd0, 32'h2);
        applyStimulus(1'b1, 32'h20, 1'b0, 2'd2, 5'd0, 1'b1, 3'd0, 32'h0, 1'b0, 1'b0, 8'h00);
        evalCycle();
        checkOutput("eret_new_pc", new_pc, 32'h300);
        checkOutput("eret_flush", {28'd0, if_flush, id_flush, ex_flush, mem_flush}, 32'hF);
        endCycle();
        applyIdle();
        evalCycle();
        readCreg("eret_status", 5'd0, 32'h3);
        endCycle();

        // Trap held off by mem_busy for three cycles
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h500, 1'b0, 2'd0, 5'd1, 1'b0, 3'd5, 32'h0, 1'b0, 1'b1, 8'h00);
            evalCycle();
            checkOutput("stall_noflush", 32'(if_flush), 32'd0);
            checkOutput("stall_sig", 32'(ex_stall), 32'd1);
            readCreg("stall_epc", 5'd3, 32'h300);
            endCycle();
        end
        applyStimulus(1'b1, 32'h500, 1'b0, 2'd0, 5'd1, 1'b0, 3'd5, 32'h0, 1'b0, 1'b0, 8'h00);
        evalCycle();
        checkOutput("stall_taken", 32'(if_flush), 32'd1);
        endCycle();
        applyIdle();
        evalCycle();
        readCreg("stall_epc_after", 5'd3, 32'h500);
        readCreg("stall_cause", 5'd2, 32'h5);
        endCycle();

        // Reset arriving in the flush cycle
        applyStimulus(1'b1, 32'h600, 1'b0, 2'd0, 5'd0, 1'b1, 3'd3, 32'h0, 1'b0, 1'b0, 8'h00);
        evalCycle();
        checkOutput("rst_pre_flush", 32'(if_flush), 32'd1);
        reset = 1'b1;
        applyIdle();
        modelReset();
        readCreg("rst_status", 5'd0, 32'd0);
        readCreg("rst_int_mask", 5'd1, 32'hFF);
        readCreg("rst_epc", 5'd3, 32'd0);
        checkOutput("rst_flush", 32'(if_flush), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            applyStimulus(($urandom % 8) != 0, $urandom & 32'hFFFF_FFFC, 1'($urandom),
                          2'($urandom), 5'($urandom % 8), 1'($urandom),
                          ($urandom % 6 == 0) ? 3'($urandom_range(1, 6)) : 3'd0, $urandom,
                          ($urandom % 10) == 0, ($urandom % 10) == 0,
                          ($urandom % 4 == 0) ? 8'($urandom) : 8'd0);
            creg_rd_addr = 5'($urandom % 8);
            evalCycle();
            endCycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
